// File: rtl/imm_gen.sv
// RV32I immediate generator, decode stage.
// One-cycle registered decode of immediate value and format.
module imm_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [29:0] instr,
  output logic        out_valid,
  output logic [31:0] imm,
  output logic [2:0]  imm_type,
  output logic        has_imm
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  logic [31:0] w_inst;
  logic [4:0]  w_opc;
  logic        w_is_i;
  logic        w_is_s;
  logic        w_is_b;
  logic        w_is_u;
  logic        w_is_j;
  fmt_e        w_fmt;
  logic [31:0] w_imm;

  logic        r_valid;
  logic [31:0] r_imm;
  fmt_e        r_fmt;
  logic        r_has;

  // Low two bits are always 2'b11 for 32-bit encodings.
  assign w_inst = {instr, 2'b11};
  assign w_opc  = w_inst[6:2];

  assign w_is_i = (w_opc == 5'b00000) ||
                  (w_opc == 5'b00011) ||
                  (w_opc == 5'b00100) ||
                  (w_opc == 5'b11001) ||
                  (w_opc == 5'b11100);
  assign w_is_s = (w_opc == 5'b01000);
  assign w_is_b = (w_opc == 5'b11000);
  assign w_is_u = (w_opc == 5'b01101) ||
                  (w_opc == 5'b00101);
  assign w_is_j = (w_opc == 5'b11011);

  always_comb begin
    w_fmt = FMT_NONE;
    unique case (1'b1)
      w_is_i:  w_fmt = FMT_I;
      w_is_s:  w_fmt = FMT_S;
      w_is_b:  w_fmt = FMT_B;
      w_is_u:  w_fmt = FMT_U;
      w_is_j:  w_fmt = FMT_J;
      default: w_fmt = FMT_NONE;
    endcase
  end

  // Shift-immediates keep the full 12-bit field; shamt is cut downstream.
  always_comb begin
    w_imm = 32'h0;
    unique case (w_fmt)
      FMT_I: w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
      FMT_S: w_imm = {{20{w_inst[31]}}, w_inst[31:25],
                      w_inst[11:7]};
      FMT_B: w_imm = {{19{w_inst[31]}}, w_inst[31],
                      w_inst[7], w_inst[30:25],
                      w_inst[11:8], 1'b0};
      FMT_U: w_imm = {w_inst[31:12], 12'h0};
      FMT_J: w_imm = {{11{w_inst[31]}}, w_inst[31],
                      w_inst[19:12], w_inst[20],
                      w_inst[30:21], 1'b0};
      default: w_imm = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_imm   <= 32'h0;
      r_fmt   <= FMT_NONE;
      r_has   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_imm <= w_imm;
        r_fmt <= w_fmt;
        r_has <= (w_fmt != FMT_NONE);
      end
    end
  end

  assign out_valid = r_valid;
  assign imm       = r_imm;
  assign imm_type  = r_fmt;
  assign has_imm   = r_has;

endmodule

// File: tb/tb_imm_gen.sv
// Directed self-checking bench for imm_gen.
// Each task drives vectors and compares registered outputs.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [29:0] instr;
  logic        out_valid;
  logic [31:0] imm;
  logic [2:0]  imm_type;
  logic        has_imm;

  int n_checks = 0;
  int n_fail   = 0;

  imm_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .instr    (instr),
    .out_valid(out_valid),
    .imm      (imm),
    .imm_type (imm_type),
    .has_imm  (has_imm)
  );

  always #5 clk = ~clk;

  // Drive at negedge, sample 1 time unit after the next posedge.
  task automatic step(input logic rst, input logic v,
                      input logic [31:0] ins);
    @(negedge clk);
    rst_n    = rst;
    in_valid = v;
    instr    = ins[31:2];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [36:0] got;
    step(1'b0, 1'b1, 32'h00510093);
    got = {out_valid, imm, imm_type, has_imm};
    n_checks++;
    if (got !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_init got=%h exp=%h", got, 37'h0);
    end
    step(1'b0, 1'b1, 32'hFFF00093);
    got = {out_valid, imm, imm_type, has_imm};
    n_checks++;
    if (got !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=%h", got, 37'h0);
    end
  endtask

  task automatic test_formats;
    logic [31:0] ins [11];
    logic [31:0] ei  [11];
    logic [2:0]  et  [11];
    logic [36:0] got;
    logic [36:0] exp;
    ins = '{32'h00510093, 32'h00512423, 32'h00208263,
            32'h123450B7, 32'h020000EF, 32'hFFF00093,
            32'h80000063, 32'hFFFFF0EF, 32'h4030D093,
            32'h30029073, 32'h002081B3};
    ei  = '{32'h00000005, 32'h00000008, 32'h00000004,
            32'h12345000, 32'h00000020, 32'hFFFFFFFF,
            32'hFFFFF000, 32'hFFFFFFFE, 32'h00000403,
            32'h00000300, 32'h00000000};
    et  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1,
            3'd3, 3'd5, 3'd1, 3'd1, 3'd0};
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b1, ins[i]);
      got = {out_valid, imm, imm_type, has_imm};
      exp = {1'b1, ei[i], et[i], (et[i] != 3'd0)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL fmt[%0d] ins=%h got=%h exp=%h",
                 i, ins[i], got, exp);
      end
    end
  endtask

  task automatic test_hold;
    logic [36:0] got;
    step(1'b1, 1'b1, 32'h002081B3);
    step(1'b1, 1'b0, 32'h00510093);
    got = {out_valid, imm, imm_type, has_imm};
    n_checks++;
    if (got !== {1'b0, 32'h0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_none got=%h exp=%h", got,
               {1'b0, 32'h0, 3'd0, 1'b0});
    end
    step(1'b1, 1'b1, 32'h123450B7);
    step(1'b1, 1'b0, 32'hFFFFF0EF);
    step(1'b1, 1'b0, 32'h00208263);
    got = {out_valid, imm, imm_type, has_imm};
    n_checks++;
    if (got !== {1'b0, 32'h12345000, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL hold_lui got=%h exp=%h", got,
               {1'b0, 32'h12345000, 3'd4, 1'b1});
    end
  endtask

  task automatic test_reset_midstream;
    logic [36:0] got;
    step(1'b1, 1'b1, 32'hFFFFF0EF);
    step(1'b0, 1'b1, 32'h00510093);
    got = {out_valid, imm, imm_type, has_imm};
    n_checks++;
    if (got !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_mid got=%h exp=%h", got, 37'h0);
    end
    step(1'b1, 1'b0, 32'h00510093);
    got = {out_valid, imm, imm_type, has_imm};
    n_checks++;
    if (got !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", got, 37'h0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ins [5];
    logic [31:0] ei  [5];
    logic [2:0]  et  [5];
    logic [36:0] got;
    logic [36:0] exp;
    ins = '{32'h00512423, 32'h00208263, 32'h00001517,
            32'hFFC12283, 32'h020000EF};
    ei  = '{32'h00000008, 32'h00000004, 32'h00001000,
            32'hFFFFFFFC, 32'h00000020};
    et  = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd5};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, ins[i]);
      got = {out_valid, imm, imm_type, has_imm};
      exp = {1'b1, ei[i], et[i], 1'b1};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    step(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end out_valid got=%b exp=0",
               out_valid);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    instr    = '0;
    test_reset();
    test_formats();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen.md
Name: imm_gen

Overview:
Registered RV32I immediate generator in the decode stage. It takes instruction bits [31:2] and decodes the format from the opcode. It outputs the sign-extended or shifted 32-bit immediate plus a format code. Latency is one cycle; the result feeds the ALU operand mux, branch/jump target adder and LSU address adder.

Parameters:
none (fixed RV32I, 32-bit immediate)

Ports:
clk       input   1   system clock, rising edge
rst_n     input   1   synchronous active-low reset
in_valid  input   1   instr is valid this cycle
instr     input   30  instruction bits [31:2]; bits [1:0] are implied 2'b11 and not presented
out_valid output  1   imm/imm_type/has_imm valid
imm       output  32  decoded immediate
imm_type  output  3   format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
has_imm   output  1   1 when imm_type != NONE

Behaviour:
- Reset (rst_n low at posedge clk): out_valid=0, imm=0, imm_type=0, has_imm=0.
- Latency: one cycle.
  - At posedge with in_valid=1: register the decode of instr; out_valid=1 next cycle.
  - At posedge with in_valid=0: out_valid=0; imm/imm_type/has_imm hold their previous values.
- Back-to-back valid inputs produce one result per cycle; no stall input, no backpressure.
- Opcode = instr[6:2]:
  - I-type: 00000 LOAD, 00011 MISC-MEM, 00100 OP-IMM, 11001 JALR, 11100 SYSTEM.
  - S-type: 01000 STORE.
  - B-type: 11000 BRANCH.
  - U-type: 01101 LUI, 00101 AUIPC.
  - J-type: 11011 JAL.
  - All other opcodes (OP 01100 etc.): NONE, imm=0, has_imm=0.
- Bit assembly (inst = {instr, 2'b11}):
  - I: {{20{inst[31]}}, inst[31:20]}
  - S: {{20{inst[31]}}, inst[31:25], inst[11:7]}
  - B: {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - U: {inst[31:12], 12'b0}
  - J: {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
- Shift-immediate OP-IMM (funct3 001/101) is treated as plain I-type. The full 12-bit field is sign-extended; shamt extraction belongs downstream.
- B and J immediates always have bit 0 = 0.
- Sign extension always comes from inst[31].
- Reset dominates in_valid in the same cycle. A reset mid-stream discards the in-flight result.

Test Plan:
- ADDI x1,x2,5 (0x00510093), in_valid=1 -> next cycle out_valid=1, imm=0x00000005, imm_type=1, has_imm=1.
- SW x5,8(x2) (0x00512423) -> imm=0x00000008, imm_type=2. BEQ x1,x2,+4 (0x00208263) -> imm=0x00000004, imm_type=3.
- LUI x1,0x12345 (0x123450B7) -> imm=0x12345000, imm_type=4. JAL x1,+32 (0x020000EF) -> imm=0x00000020, imm_type=5.
- Negative values: ADDI x1,x0,-1 (0xFFF00093) -> 0xFFFFFFFF.
  - BEQ with imm -4096 (0x80000063) -> 0xFFFFF000.
  - JAL -2 (0xFFFFF0EF) -> 0xFFFFFFFE.
- ADD x3,x1,x2 (0x002081B3) -> imm=0, imm_type=0, has_imm=0.
  - Then in_valid=0 for one cycle -> out_valid=0, outputs hold.
- Assert rst_n=0 with in_valid=1 -> next cycle all outputs 0.
  - Release reset, stream 5 back-to-back valid instructions -> 5 consecutive correct results, each 1 cycle after its input.
